// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  localparam int unsigned CW_DEF     = 8;
  localparam int unsigned H_DISP_DEF = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_DISP_DEF = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOT = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOT = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [CW_DEF-1:0] r;
    logic [CW_DEF-1:0] g;
    logic [CW_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock indication into the pixel clock domain.
module vga_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: lock-gated counters, request stage, and a two-stage
// alignment pipeline that lines returned RGB up with the sync/blank pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP = H_DISP_DEF,
  parameter int unsigned H_FP   = H_FP_DEF,
  parameter int unsigned H_SYNC = H_SYNC_DEF,
  parameter int unsigned H_BP   = H_BP_DEF,
  parameter int unsigned V_DISP = V_DISP_DEF,
  parameter int unsigned V_FP   = V_FP_DEF,
  parameter int unsigned V_SYNC = V_SYNC_DEF,
  parameter int unsigned V_BP   = V_BP_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          pix_req,
  output coord_t        pix_x,
  output coord_t        pix_y,
  input  logic [3*CW-1:0] pix_rgb,
  output logic          frame_start,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b
);

  localparam coord_t H_LAST = coord_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = coord_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT  = coord_t'(H_DISP);
  localparam coord_t V_ACT  = coord_t'(V_DISP);
  localparam coord_t HS_BEG = coord_t'(H_DISP + H_FP);
  localparam coord_t HS_END = coord_t'(H_DISP + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_DISP + V_FP);
  localparam coord_t VS_END = coord_t'(V_DISP + V_FP + V_SYNC);

  logic   run;
  coord_t hcnt, vcnt;
  logic   active, hs_i, vs_i;
  logic   hs_d1, vs_d1, blank_d1;

  vga_lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (run)
  );

  // Counters sit at 0 while not running so a restart always begins at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    active = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_i   = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs_i   = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      blank_d1    <= 1'b0;
    end else if (!run) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      blank_d1    <= 1'b0;
    end else begin
      pix_req     <= active;
      pix_x       <= active ? hcnt : '0;
      pix_y       <= active ? vcnt : '0;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      hs_d1       <= hs_i;
      vs_d1       <= vs_i;
      blank_d1    <= active;
    end
  end

  // Pin stage also clears on !run so loss of lock blanks the pins one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (!run) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      vga_blank_n <= blank_d1;
      {vga_r, vga_g, vga_b} <= blank_d1 ? pix_rgb : '0;
    end
  end

endmodule
